// File: rtl/encdec_pkg.sv
// Shared constants and types for the Ring-LWE encode/decode datapath.
package encdec_pkg;

    localparam int unsigned Q_DEFAULT = 7681;
    localparam int unsigned BARRETT_K = 32;

    typedef logic [13:0] coeff_t;
    typedef logic [29:0] product_t;

    // Barrett multiplier M = floor(2^K / q).
    function automatic int unsigned barrett_m(input int unsigned q);
        longint unsigned two_k;
        two_k = 64'd1 << BARRETT_K;
        return 32'(two_k / 64'(q));
    endfunction

endpackage

// File: rtl/encdec_mod_reduce_stage.sv
// One pipeline register slice: valid, payload, tag and last, advancing on en.
module encdec_mod_reduce_stage #(
    parameter int unsigned W     = 1,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_last,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_tag   <= in_tag;
            out_last  <= in_last;
        end
    end

endmodule

// File: rtl/encdec_mod_reduce.sv
// Three-stage Barrett reducer: x mod Q with in-order valid/ready handshake
// and tag/last sideband. All stages share one enable, so stalls never drop beats.
module encdec_mod_reduce
    import encdec_pkg::*;
#(
    parameter int unsigned Q      = Q_DEFAULT,
    parameter int unsigned DIN_W  = 30,
    parameter int unsigned DOUT_W = 14,
    parameter int unsigned TAG_W  = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_last
);

    // M < 2^20 for any Q above 2^12, so p = x*M needs DIN_W+20 bits.
    localparam int unsigned M_W  = 20;
    localparam int unsigned P_W  = DIN_W + M_W;
    localparam int unsigned T_W  = P_W - BARRETT_K;
    localparam int unsigned S1_W = DIN_W + P_W;
    localparam int unsigned R_W  = DOUT_W + 1;

    localparam logic [P_W-1:0]   M_P = P_W'(barrett_m(Q));
    localparam logic [DIN_W-1:0] Q_D = DIN_W'(Q);
    localparam logic [R_W-1:0]   Q_R = R_W'(Q);

    logic en;

    logic              s1_valid;
    logic [S1_W-1:0]   s1_data;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_last;
    logic [S1_W-1:0]   s1_data_next;

    logic              s2_valid;
    logic [R_W-1:0]    s2_data;
    logic [TAG_W-1:0]  s2_tag;
    logic              s2_last;
    logic [R_W-1:0]    s2_data_next;

    logic [DOUT_W-1:0] s3_data_next;

    logic [DIN_W-1:0]  x_s1;
    logic [P_W-1:0]    p_s1;
    logic [T_W-1:0]    t_s1;
    logic [DIN_W-1:0]  tq_s1;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1 input: product with the Barrett constant, left to DSP inference.
    assign s1_data_next = {in_data, P_W'(in_data) * M_P};

    // S2 input: quotient estimate and remainder; the true remainder is below 2Q,
    // so the modular DIN_W-bit subtraction truncated to R_W bits is exact.
    assign x_s1         = s1_data[P_W +: DIN_W];
    assign p_s1         = s1_data[P_W-1:0];
    assign t_s1         = T_W'(p_s1 >> BARRETT_K);
    assign tq_s1        = DIN_W'(t_s1) * Q_D;
    assign s2_data_next = R_W'(x_s1 - tq_s1);

    // S3 input: the single conditional subtract.
    assign s3_data_next = (s2_data >= Q_R) ? DOUT_W'(s2_data - Q_R) : DOUT_W'(s2_data);

    encdec_mod_reduce_stage #(.W(S1_W), .TAG_W(TAG_W)) u_s1 (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (s1_data_next),
        .in_tag    (in_tag),
        .in_last   (in_last),
        .out_valid (s1_valid),
        .out_data  (s1_data),
        .out_tag   (s1_tag),
        .out_last  (s1_last)
    );

    encdec_mod_reduce_stage #(.W(R_W), .TAG_W(TAG_W)) u_s2 (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (en),
        .in_valid  (s1_valid),
        .in_data   (s2_data_next),
        .in_tag    (s1_tag),
        .in_last   (s1_last),
        .out_valid (s2_valid),
        .out_data  (s2_data),
        .out_tag   (s2_tag),
        .out_last  (s2_last)
    );

    encdec_mod_reduce_stage #(.W(DOUT_W), .TAG_W(TAG_W)) u_s3 (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (en),
        .in_valid  (s2_valid),
        .in_data   (s3_data_next),
        .in_tag    (s2_tag),
        .in_last   (s2_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_last  (out_last)
    );

endmodule
